branch_predictor: RTL



---
 rtl/branch_predictor.sv | 111 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor.
// 2-bit saturating counter table with self-initialisation and perf counters.
module branch_predictor #(
  parameter int         INDEX_WIDTH = 6,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_e_i,
  input  logic [1:0]  branch_op_e_i,
  input  logic        stall_e_i,
  input  logic        pc_src_pred_e_i,
  input  logic        pc_src_res_e_i,
  input  logic        clear_cnt_i,
  output logic        pc_src_pred_f_o,
  output logic        ready_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [INDEX_WIDTH-1:0] init_idx;
  logic [1:0]             tbl_q [DEPTH];
  logic [INDEX_WIDTH-1:0] f_idx;
  logic [INDEX_WIDTH-1:0] e_idx;
  logic                   run;
  logic                   upd;
  logic                   miss;
  logic [1:0]             cur;
  logic [1:0]             nxt;
  logic                   unused_bits;

  assign f_idx = pc_f_i[INDEX_WIDTH+1:2];
  assign e_idx = pc_e_i[INDEX_WIDTH+1:2];
  assign run   = (state_q == S_RUN);
  assign upd   = run & branch_op_e_i[0] & ~stall_e_i;
  assign miss  = pc_src_pred_e_i ^ pc_src_res_e_i;

  assign ready_o         = run;
  assign pc_src_pred_f_o = run & tbl_q[f_idx][1];

  assign unused_bits = ^{pc_f_i[31:INDEX_WIDTH+2], pc_f_i[1:0],
                         pc_e_i[31:INDEX_WIDTH+2], pc_e_i[1:0],
                         branch_op_e_i[1]};

  // State register and init sweep index.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_INIT;
      init_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) init_idx <= init_idx + 1'b1;
    end
  end

  // Leave INIT on the edge that writes the last entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (init_idx == '1) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Saturating step of the entry being trained.
  always_comb begin
    cur = tbl_q[e_idx];
    nxt = cur;
    if (pc_src_res_e_i) begin
      if (cur != 2'b11) nxt = cur + 2'd1;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'd1;
    end
  end

  // Table storage: init sweep writes, then training writes; no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) begin
      tbl_q[init_idx] <= INIT_STATE;
    end else if (upd) begin
      tbl_q[e_idx] <= nxt;
    end
  end

  // Saturating perf counters; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (clear_cnt_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (upd) begin
      if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + 32'd1;
      if (miss && mispred_cnt_o != '1)
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end

endmodule
